// File: rtl/uart_pkg.sv
// Shared constants and types for the USART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StBit9  = 3'd3,
    StStop  = 3'd4
  } rx_state_e;

  localparam int unsigned Oversample   = 16;
  localparam logic [3:0]  SampleFirst  = 4'd7;
  localparam logic [3:0]  SampleMid    = 4'd8;
  localparam logic [3:0]  SampleDecide = 4'd9;
  localparam logic [3:0]  SampleLast   = 4'(Oversample - 1);

  localparam int unsigned RxEntryW     = 10;
  localparam int unsigned EntryFerrPos = 9;
  localparam int unsigned EntryBit9Pos = 8;

  function automatic logic majority3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [RxEntryW-1:0] pack_entry(logic fe, logic b9, logic [7:0] data);
    logic [RxEntryW-1:0] e;
    e               = '0;
    e[7:0]          = data;
    e[EntryBit9Pos] = b9;
    e[EntryFerrPos] = fe;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// RCREG receive FIFO; a write while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Width = RxEntryW,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_wr, do_rd;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full  = (cnt_q == CntW'(Depth));
    empty = (cnt_q == '0);
    do_rd = rd_en && !empty;
    do_wr = wr_en && (!full || do_rd);
    head  = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Asynchronous USART receiver with 16x oversampling and a 2-entry RCREG FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_RXD,
  input  logic       rx_sample_en,
  input  logic       rx9,
  input  logic       cren,
  input  logic       aden,
  input  logic       rcreg_rd_en,
  output logic [7:0] rcreg_out,
  output logic       rx9d,
  output logic       ferr,
  output logic       oerr,
  output logic       rxif_set_en
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  rx_state_e              state_q;
  logic [3:0]             cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [8:0]             rsr_q;
  logic                   s8_q;
  logic                   bit_val;
  logic                   wr_q;
  logic [RxEntryW-1:0]    wr_entry_q;
  logic                   oerr_q;
  logic                   fifo_full, fifo_empty;
  logic [RxEntryW-1:0]    fifo_head;

`ifdef UART_RX_MAJORITY_EN
  logic s7_q;
  assign bit_val = majority3(s7_q, s8_q, rxs);
`else
  assign bit_val = s8_q;
`endif

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= UART_RXD;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  wire decide = rx_sample_en && (cnt_q == SampleDecide);
  wire last   = rx_sample_en && (cnt_q == SampleLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      rsr_q      <= '0;
      s8_q       <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      s7_q       <= 1'b1;
`endif
      wr_q       <= 1'b0;
      wr_entry_q <= '0;
    end else begin
      wr_q <= 1'b0;
      if (!cren) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        if (rx_sample_en && (state_q != StIdle)) begin
          cnt_q <= cnt_q + 4'd1;
`ifdef UART_RX_MAJORITY_EN
          if (cnt_q == SampleFirst) s7_q <= rxs;
`endif
          if (cnt_q == SampleMid) s8_q <= rxs;
        end
        unique case (state_q)
          StIdle: begin
            if (!oerr_q && !rxs) begin
              state_q   <= StStart;
              cnt_q     <= '0;
              bit_cnt_q <= '0;
              rsr_q     <= '0;
            end
          end
          StStart: begin
            if (decide && bit_val) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (last) begin
              state_q <= StData;
            end
          end
          StData: begin
            if (decide) rsr_q[7:0] <= {bit_val, rsr_q[7:1]};
            if (last) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= rx9 ? StBit9 : StStop;
            end
          end
          StBit9: begin
            if (decide) rsr_q[8] <= bit_val;
            if (last) state_q <= StStop;
          end
          StStop: begin
            if (decide) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              // Address-detect mode drops data frames (9th bit clear).
              if (!(rx9 && aden && !rsr_q[8])) begin
                wr_q       <= 1'b1;
                wr_entry_q <= pack_entry(!bit_val, rx9 && rsr_q[8], rsr_q[7:0]);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oerr_q <= 1'b0;
    end else if (!cren) begin
      oerr_q <= 1'b0;
    end else if (wr_q && fifo_full && !rcreg_rd_en) begin
      oerr_q <= 1'b1;
    end
  end

  uart_rx_fifo #(
    .Width(RxEntryW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_q),
    .wr_data(wr_entry_q),
    .rd_en  (rcreg_rd_en),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  assign rcreg_out   = fifo_head[7:0];
  assign rx9d        = fifo_head[EntryBit9Pos];
  assign ferr        = fifo_head[EntryFerrPos];
  assign oerr        = oerr_q;
  assign rxif_set_en = !fifo_empty;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       UART_RXD = 1'b1;
  logic       rx_sample_en = 1'b0;
  logic       rx9 = 1'b0;
  logic       cren = 1'b1;
  logic       aden = 1'b0;
  logic       rcreg_rd_en = 1'b0;
  logic [7:0] rcreg_out;
  logic       rx9d, ferr, oerr, rxif_set_en;

  int  vectors = 0;
  int  errors  = 0;
  int  sc      = 0;
  bit  chk_en  = 1'b0;

  // Model: queue of {ferr, bit9, data} entries and the sticky overrun flag.
  logic [9:0] mq[$];
  bit         oerr_m = 1'b0;

  uart_rx #(
    .SYNC_STAGES(2),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .UART_RXD    (UART_RXD),
    .rx_sample_en(rx_sample_en),
    .rx9         (rx9),
    .cren        (cren),
    .aden        (aden),
    .rcreg_rd_en (rcreg_rd_en),
    .rcreg_out   (rcreg_out),
    .rx9d        (rx9d),
    .ferr        (ferr),
    .oerr        (oerr),
    .rxif_set_en (rxif_set_en)
  );

  always #5 clk = ~clk;

  // 16x strobe: one cycle in four.
  initial begin
    forever begin
      @(negedge clk);
      sc++;
      rx_sample_en = (sc % 4 == 0);
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] model_head();
    return (mq.size() > 0) ? mq[0] : 10'h0;
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      logic [9:0] h;
      h = model_head();
      cmp("model.rcreg_out", 32'(rcreg_out), 32'(h[7:0]));
      cmp("model.rx9d", 32'(rx9d), 32'(h[8]));
      cmp("model.ferr", 32'(ferr), 32'(h[9]));
      cmp("model.oerr", 32'(oerr), 32'(oerr_m));
      cmp("model.rxif", 32'(rxif_set_en), 32'(mq.size() > 0));
    end
  end

  task automatic wait_strobes(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (rx_sample_en) k++;
    end
  endtask

  task automatic settle(input int n);
    chk_en = 1'b1;
    repeat (n) @(negedge clk);
    chk_en = 1'b0;
  endtask

  // One bit period; optionally invert the line for the single strobe at count 8.
  task automatic drive_bit(input logic v, input bit spike);
    @(negedge clk);
    UART_RXD = v;
    if (spike) begin
      wait_strobes(8);
      @(negedge clk);
      UART_RXD = ~v;
      wait_strobes(1);
      @(negedge clk);
      UART_RXD = v;
      wait_strobes(7);
    end else begin
      wait_strobes(16);
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic b9, input logic stopv);
    if (oerr_m) return;
    if (rx9 && aden && !b9) return;
    if (mq.size() == 2) oerr_m = 1'b1;
    else mq.push_back({~stopv, rx9 & b9, d});
  endtask

  task automatic send_frame(input logic [7:0] d, input logic b9, input logic stopv,
                            input int spike_bit);
    chk_en = 1'b0;
    wait_strobes(1);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], spike_bit == i);
    if (rx9) drive_bit(b9, 1'b0);
    drive_bit(stopv, 1'b0);
    drive_bit(1'b1, 1'b0);
    model_frame(d, b9, stopv);
    settle(6);
  endtask

  task automatic pop();
    chk_en = 1'b0;
    @(negedge clk);
    rcreg_rd_en = 1'b1;
    @(negedge clk);
    rcreg_rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    settle(4);
  endtask

  task automatic cren_pulse();
    chk_en = 1'b0;
    @(negedge clk);
    cren = 1'b0;
    @(negedge clk);
    cren = 1'b1;
    oerr_m = 1'b0;
    settle(4);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    UART_RXD = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    oerr_m = 1'b0;
    settle(4);
  endtask

  task automatic lit_all(input string nm, input logic [7:0] d, input logic b9, input logic fe,
                         input logic oe, input logic rxif);
    cmp({nm, ".rcreg_out"}, 32'(rcreg_out), 32'(d));
    cmp({nm, ".rx9d"}, 32'(rx9d), 32'(b9));
    cmp({nm, ".ferr"}, 32'(ferr), 32'(fe));
    cmp({nm, ".oerr"}, 32'(oerr), 32'(oe));
    cmp({nm, ".rxif"}, 32'(rxif_set_en), 32'(rxif));
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    settle(4);
    lit_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Plain 8-bit frame, then pop to empty.
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    lit_all("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    pop();
    lit_all("a5_pop", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Framing error, then a good frame behind it.
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    lit_all("ferr_3c", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'h11, 1'b0, 1'b1, -1);
    lit_all("ferr_head_kept", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    pop();
    lit_all("good_11", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    pop();

    // Overrun and reception inhibit until cren is pulsed.
    send_frame(8'h01, 1'b0, 1'b1, -1);
    send_frame(8'h02, 1'b0, 1'b1, -1);
    send_frame(8'h03, 1'b0, 1'b1, -1);
    lit_all("overrun", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    pop();
    lit_all("overrun_pop1", 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
    pop();
    lit_all("overrun_pop2", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h04, 1'b0, 1'b1, -1);
    lit_all("inhibited", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cren_pulse();
    lit_all("cren_clear", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 9-bit address detect.
    @(negedge clk);
    rx9 = 1'b1;
    aden = 1'b1;
    send_frame(8'h55, 1'b0, 1'b1, -1);
    lit_all("aden_drop", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h80, 1'b1, 1'b1, -1);
    lit_all("aden_addr", 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    pop();
    @(negedge clk);
    rx9 = 1'b0;
    aden = 1'b0;

    // Short low glitch is a false start.
    wait_strobes(1);
    @(negedge clk);
    UART_RXD = 1'b0;
    wait_strobes(4);
    @(negedge clk);
    UART_RXD = 1'b1;
    wait_strobes(32);
    settle(4);
    lit_all("glitch", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h5A, 1'b0, 1'b1, 3);
    lit_all("spike", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    pop();
`endif

    // Reset in the middle of a frame with a byte already queued.
    send_frame(8'h33, 1'b0, 1'b1, -1);
    wait_strobes(1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    do_reset();
    lit_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b1, -1);
    lit_all("after_reset", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
    pop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous UART receiver for the pic16f-antastic USART, the receive-side companion to the existing transmit path. It oversamples UART_RXD using the 16x strobe from the baud rate generator and shifts frames into a receive shift register. Completed frames go into the 2-deep RCREG FIFO, and the block drives the RCSTA status bits (RX9D, FERR, OERR) and the RXIF set strobe. Only asynchronous mode is supported.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop stages on UART_RXD before any use.
- FIFO_DEPTH, 2, RCREG FIFO entries; fixed at 2 for PIC compatibility.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- UART_RXD  in  1  serial input; idle high
- rx_sample_en  in  1  one-cycle strobe at 16x baud, from the baud generator
- rx9  in  1  RCSTA[6]; 9-bit receive mode
- cren  in  1  RCSTA[4]; continuous receive enable
- aden  in  1  RCSTA[3]; address detect enable (used only when rx9=1)
- rcreg_rd_en  in  1  core read of RCREG; pops the FIFO head
- rcreg_out  out  8  FIFO head data byte
- rx9d  out  1  FIFO head 9th bit
- ferr  out  1  FIFO head framing error
- oerr  out  1  overrun error, sticky
- rxif_set_en  out  1  high while the FIFO is non-empty

## Operation
- UART_RXD passes through SYNC_STAGES flip-flops. Everything below uses the synchronized signal `rxs`.
- State machine states: IDLE, START, DATA, BIT9, STOP. A sample counter (4 bits, 0..15) advances on each rx_sample_en and wraps from 15 to 0. A bit counter (3 bits) counts data bits.
- IDLE: when cren=1, oerr=0 and rxs=0 → START, sample counter cleared.
- Each bit period is 16 strobes. The bit value is decided at count 9 (see Configuration).
- START: decided value 1 is a false start → IDLE. Decided value 0 → DATA at count 15.
- DATA: 8 bits, LSB first, shifted into a 9-bit RSR. After the 8th bit: rx9=1 → BIT9, otherwise → STOP.
- BIT9: captures RSR[8].
- STOP: the decided stop value is 0 → frame flagged with ferr=1. The frame is written at the stop-bit decision point, then the block returns to IDLE without waiting out the remainder of the stop bit.
- Write filter: when rx9=1, aden=1 and RSR[8]=0, the frame is discarded and nothing is written.
- FIFO entry = {ferr, bit9, data[7:0]}, 10 bits. rcreg_out, rx9d and ferr always show the head entry, or 0 when the FIFO is empty.
- Overrun: a write arrives with the FIFO full and no simultaneous pop → frame discarded, oerr set to 1. While oerr=1, reception is inhibited: the FSM stays in IDLE. The FIFO remains readable.
- cren=0: forces the FSM to IDLE, aborts any frame in progress, and clears oerr. FIFO contents are kept.
- Simultaneous write and pop: both take effect and the occupancy is unchanged. A write when full with a simultaneous pop is accepted and does not set oerr.
- Pop on an empty FIFO is ignored.
- Reset: FSM to IDLE, counters 0, FIFO emptied. rcreg_out=0, rx9d=0, ferr=0, oerr=0, rxif_set_en=0.

## Timing
- The synchronizer adds SYNC_STAGES cycles between a UART_RXD change and the FSM seeing it.
- FIFO write: in the cycle after the rx_sample_en that decides the last bit. rcreg_out, rx9d, ferr and rxif_set_en update on the following clock edge.
- Pop: the new head appears on the clock edge after rcreg_rd_en. rxif_set_en falls on the same edge when the FIFO empties.
- oerr rises on the same edge as the rejected write. It clears on the edge after cren is sampled 0.
- rx_sample_en may be continuously high; counting is then per clock cycle.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of rxs sampled at counts 7, 8 and 9. The decision is made at count 9.
- UART_RX_MAJORITY_EN undefined: each bit value is the single rxs sample at count 8, registered and used at count 9. Decision timing is identical in both builds.

## Structure
- Shared package uart_pkg holds:
  - state encodings (localparams for IDLE, START, DATA, BIT9, STOP)
  - OVERSAMPLE=16 and the sample-point constants 7, 8, 9
  - RX_ENTRY_W=10 and the bit positions of ferr and bit9 within an entry
- One sub-module, uart_rx_fifo: 2-entry synchronous FIFO with wr_en, rd_en, full, empty and head output. It implements the simultaneous write/pop rules above.

## Test plan
- 8-bit frame 0xA5 with a valid stop bit, rx_sample_en every 4 clocks → rcreg_out=0xA5, ferr=0, rxif_set_en=1. A pop then gives rxif_set_en=0.
- Stop bit driven 0 on 0x3C → rcreg_out=0x3C, ferr=1. Next good frame 0x11 popped into the head → ferr=0.
- Three frames 0x01, 0x02, 0x03 with no reads → oerr=1 and head stays 0x01. Pops return 0x01 then 0x02. A 4th frame is ignored until cren is pulsed 0, which clears oerr.
- rx9=1, aden=1: frame 0x55 with 9th bit 0 is not written; frame 0x80 with 9th bit 1 gives rcreg_out=0x80, rx9d=1.
- 4-sample-wide low glitch on UART_RXD → FSM returns to IDLE and nothing is written. With the macro defined, a 1-sample spike inverted at count 8 of a data bit leaves the byte intact.
- rst asserted mid-DATA → all outputs 0, FIFO empty. The next clean frame 0x7E is received correctly.
